pattern_sequence_transmitter: RTL
=================================

PATTERN_SEQUENCE_TRANSMITTER -- requirements
Module: pattern_sequence_transmitter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pattern register width; legal range 2..16.
REQ-002 SHALL have parameter GAP, default 2: number of idle zero bits inserted between repeated passes; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a transmission; sampled in IDLE only.
REQ-006 SHALL have port pattern, input, WIDTH bits: bit pattern to serialize; latched on an accepted start.
REQ-007 SHALL have port length, input, 5 bits: number of pattern bits per pass; latched on an accepted start.
REQ-008 SHALL have port repeat, input, 4 bits: pass count; 0 means continuous; latched on an accepted start.
REQ-009 SHALL have port stop, input, 1 bit: abort request while busy.
REQ-010 SHALL have port dataout, output, 1 bit: serial bit stream; feeds a bit-serial pattern detector directly.
REQ-011 SHALL have port valid, output, 1 bit: high when dataout carries a pattern bit.
REQ-012 SHALL have port busy, output, 1 bit: high in SHIFT and GAP.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port state, output, 3 bits: current FSM state, for debug.

Function
REQ-015 SHALL implement FSM states IDLE=3'd0, SHIFT=3'd1, GAP=3'd2, DONE=3'd3; state codes 4..7 SHALL return to IDLE on the next edge.
REQ-016 All outputs SHALL be registered.
REQ-017 IDLE, start=1: on that edge, latch pattern, effective length (length=0 or length>WIDTH gives WIDTH) and repeat; enter SHIFT.
REQ-018 Latency: the first bit SHALL appear on dataout in the cycle immediately after the start-sampling edge.
REQ-019 SHIFT: one bit per clock, order latched_pattern[len-1] down to [0]; valid=1, busy=1.
REQ-020 Last bit of a pass: the pass counter increments. Then:
- if repeat!=0 and the counter equals repeat: go to DONE;
- else if GAP>0: go to GAP;
- else: restart the pass in SHIFT, with no bubble cycle.
REQ-021 GAP: dataout=0, valid=0, busy=1 for exactly GAP cycles, then SHIFT, restarting at bit len-1.
REQ-022 DONE: exactly one cycle with done=1, busy=0, valid=0, dataout=0; then IDLE.
REQ-023 stop=1 in SHIFT or GAP SHALL force DONE on the next edge, regardless of position in the pass.
REQ-024 Priority: rst > stop > normal progress.
REQ-025 start SHALL be ignored in SHIFT, GAP and DONE; changes on pattern, length or repeat while busy SHALL have no effect.
REQ-026 The pass counter SHALL be 4 bits; in continuous mode it SHALL wrap silently from 15 to 0 and never terminate the transmission.
REQ-027 IDLE outputs: dataout=0, valid=0, busy=0, done=0; stop SHALL be ignored in IDLE.

Reset
REQ-028 rst=1 at a clock edge SHALL force the IDLE state on that edge: state=0, dataout=0, valid=0, busy=0, done=0, and all internal counters and latched registers cleared.
REQ-029 Reset mid-transmission SHALL produce no done pulse; start in the cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-030 pattern=8'b00000101, length=3, repeat=1, single start pulse -> dataout 1,0,1 in cycles 1-3 with valid=1; done=1 in cycle 4; state=0 in cycle 5.
REQ-031 Same pattern, repeat=3, GAP=2 -> dataout 1,0,1,0,0,1,0,1,0,0,1,0,1 over cycles 1-13; valid low only in the 4 gap cycles; done in cycle 14.
REQ-032 length=0, pattern=8'hA5, repeat=1 -> 8 bits 1,0,1,0,0,1,0,1 in cycles 1-8, then done.
REQ-033 repeat=0, GAP=0, pattern 101, stop asserted in cycle 7 -> stream 1,0,1,1,0,1,1, then DONE in cycle 8 with a single done pulse.
REQ-034 rst asserted in cycle 2 of a transmission -> outputs zero from the next cycle, no done pulse; a new start then restarts from bit len-1.
REQ-035 start re-asserted with a different pattern during SHIFT -> stream unchanged, and no second transmission after DONE.

Source files
------------

// File: rtl/pattern_sequence_transmitter_if.sv
// Bundle of the control/data inputs and the registered status outputs of the
// pattern sequence transmitter. The master side drives requests; the slave
// side is the transmitter itself.
interface pattern_sequence_transmitter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [4:0]       length;
  // "repeat" is a reserved word, so the pass count travels as repeat_count
  logic [3:0]       repeat_count;
  logic             stop;
  logic             dataout;
  logic             valid;
  logic             busy;
  logic             done;
  logic [2:0]       state;

  modport master (
    output start, pattern, length, repeat_count, stop,
    input  dataout, valid, busy, done, state
  );

  modport slave (
    input  start, pattern, length, repeat_count, stop,
    output dataout, valid, busy, done, state
  );
endinterface

// File: rtl/pattern_sequence_transmitter.sv
// Serializes a latched bit pattern MSB-first (from bit len-1 down to 0) for a
// programmable number of passes, with GAP idle zero bits between passes.
// repeat_count == 0 means run until stop. Every output is a flop.
module pattern_sequence_transmitter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input logic                          clk,
  input logic                          rst,
  pattern_sequence_transmitter_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  localparam logic [4:0] WIDTH_L  = 5'(WIDTH);
  // Only meaningful when GAP > 0; the GAP state is unreachable otherwise
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  logic [2:0]       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       pass_q, pass_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [4:0]       len_q, len_d;
  logic [3:0]       rep_q, rep_d;

  logic             dataout_q, valid_q, busy_q, done_q;
  logic             dataout_d, valid_d, busy_d, done_d;

  logic [4:0]       len_eff;
  logic [3:0]       pass_inc;
  logic [WIDTH-1:0] shifted;

  // Zero or oversized length requests fall back to the full register width
  assign len_eff = ((bus.length == 5'd0) || (bus.length > WIDTH_L)) ? WIDTH_L : bus.length;

  // State register: FSM state, counters, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      pass_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      dataout_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      pass_q    <= pass_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: stop outranks pass/gap progress; start only heard in IDLE
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    pass_d   = pass_q;
    pat_d    = pat_q;
    len_d    = len_q;
    rep_d    = rep_q;
    pass_inc = pass_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          pat_d   = bus.pattern;
          len_d   = len_eff;
          rep_d   = bus.repeat_count;
          idx_d   = len_eff - 5'd1;
          pass_d  = 4'd0;
          gap_d   = 4'd0;
        end
      end
      S_SHIFT: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (idx_q == 5'd0) begin
          // Counter wraps freely in continuous mode since rep_q == 0 never matches
          pass_d = pass_inc;
          if ((rep_q != 4'd0) && (pass_inc == rep_q)) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = 4'd0;
          end else begin
            idx_d = len_q - 5'd1;
          end
        end else begin
          idx_d = idx_q - 5'd1;
        end
      end
      S_GAP: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_SHIFT;
          idx_d   = len_q - 5'd1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs can be registered without lag
  always_comb begin
    dataout_d = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    shifted   = pat_d >> idx_d;
    case (state_d)
      S_SHIFT: begin
        dataout_d = shifted[0];
        valid_d   = 1'b1;
        busy_d    = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.dataout = dataout_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule
